// File: rtl/cordic_pkg.sv
// Shared types and constants for the pipelined CORDIC engine.
// The arctangent table is derived at elaboration time from a high-precision integer table.
package cordic_pkg;

  typedef enum logic {
    MODE_ROT = 1'b0,
    MODE_VEC = 1'b1
  } cordic_mode_e;

  // Aggregate gain K ~ 1.64676 in Q15, for scaling expected results.
  localparam int unsigned CORDIC_GAIN_Q15 = 53961;

  localparam int unsigned ATAN_TAB_LEN = 31;

  // round(atan(2^-i) / pi * 1e10); integer-only so elaboration needs no real math.
  localparam longint ATAN_E10 [ATAN_TAB_LEN] = '{
    64'd2500000000, 64'd1475836177, 64'd779791304, 64'd395834242,
    64'd198685243,  64'd99439478,   64'd49731873,  64'd24867454,
    64'd12433917,   64'd6216982,    64'd3108494,   64'd1554247,
    64'd777124,     64'd388562,     64'd194281,    64'd97140,
    64'd48570,      64'd24285,      64'd12143,     64'd6071,
    64'd3036,       64'd1518,       64'd759,       64'd379,
    64'd190,        64'd95,         64'd47,        64'd24,
    64'd12,         64'd6,          64'd3
  };

  // round(atan(2^-i) * 2^(width-1) / pi); valid for width <= 32.
  function automatic longint atan_entry(input int unsigned i, input int unsigned width);
    longint scaled;
    if (i >= ATAN_TAB_LEN) begin
      return 64'sd0;
    end
    scaled = ATAN_E10[i] * (64'sd1 <<< (width - 1));
    return (scaled + 64'sd5000000000) / 64'sd10000000000;
  endfunction

endpackage

// File: rtl/cordic_pipe_iter.sv
// One registered CORDIC micro-rotation with a fixed arithmetic shift.
// Data registers load only with a valid sample so idle cycles leave outputs untouched.
module cordic_iter
  import cordic_pkg::*;
#(
  parameter int unsigned SHIFT = 0,
  parameter int unsigned DW    = 18,
  parameter int unsigned AW    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 valid_in,
  input  logic                 mode_in,
  input  logic signed [DW-1:0] x_in,
  input  logic signed [DW-1:0] y_in,
  input  logic signed [AW-1:0] z_in,
  input  logic signed [AW-1:0] atan,
  output logic                 valid_out,
  output logic                 mode_out,
  output logic signed [DW-1:0] x_out,
  output logic signed [DW-1:0] y_out,
  output logic signed [AW-1:0] z_out
);

  logic                 pos;
  logic signed [DW-1:0] x_sh;
  logic signed [DW-1:0] y_sh;
  logic signed [DW-1:0] x_nx;
  logic signed [DW-1:0] y_nx;
  logic signed [AW-1:0] z_nx;

  always_comb begin
    x_sh = x_in >>> SHIFT;
    y_sh = y_in >>> SHIFT;
    // z == 0 and y < 0 both select the subtracting direction
    if (mode_in == MODE_ROT) begin
      pos = ~z_in[AW-1];
    end else begin
      pos = y_in[DW-1];
    end
    if (pos) begin
      x_nx = x_in - y_sh;
      y_nx = y_in + x_sh;
      z_nx = z_in - atan;
    end else begin
      x_nx = x_in + y_sh;
      y_nx = y_in - x_sh;
      z_nx = z_in + atan;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_out <= 1'b0;
      mode_out  <= 1'b0;
      x_out     <= '0;
      y_out     <= '0;
      z_out     <= '0;
    end else if (en) begin
      valid_out <= valid_in;
      if (valid_in) begin
        mode_out <= mode_in;
        x_out    <= x_nx;
        y_out    <= y_nx;
        z_out    <= z_nx;
      end
    end
  end

endmodule

// File: rtl/cordic_pipe.sv
// Fully pipelined CORDIC: quadrant pre-rotation register followed by STAGES micro-rotations.
// A single global enable freezes every stage while the output is held by downstream.
module cordic_pipe
  import cordic_pkg::*;
#(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned STAGES = 14,
  parameter int unsigned GUARD  = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       in_mode,
  input  logic signed [WIDTH-1:0]    in_x,
  input  logic signed [WIDTH-1:0]    in_y,
  input  logic signed [WIDTH-1:0]    in_z,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       out_mode,
  output logic signed [WIDTH+GUARD-1:0] out_x,
  output logic signed [WIDTH+GUARD-1:0] out_y,
  output logic signed [WIDTH-1:0]    out_z
);

  localparam int unsigned DW = WIDTH + GUARD;
  localparam logic signed [WIDTH-1:0] QTR = WIDTH'(1) << (WIDTH - 2);

  logic stall;
  logic en;

  logic                    vp [0:STAGES];
  logic                    mp [0:STAGES];
  logic signed [DW-1:0]    xp [0:STAGES];
  logic signed [DW-1:0]    yp [0:STAGES];
  logic signed [WIDTH-1:0] zp [0:STAGES];

  logic                    v0;
  logic                    m0;
  logic signed [DW-1:0]    x0;
  logic signed [DW-1:0]    y0;
  logic signed [WIDTH-1:0] z0;

  logic signed [DW-1:0]    xe;
  logic signed [DW-1:0]    ye;
  logic signed [DW-1:0]    xq;
  logic signed [DW-1:0]    yq;
  logic signed [WIDTH-1:0] zq;

  assign stall    = vp[STAGES] & ~out_ready;
  assign en       = ~stall;
  assign in_ready = ~stall;

  // Fold the input into the +/-pi/2 convergence range by a +/-90 degree swap.
  always_comb begin
    xe = DW'(in_x);
    ye = DW'(in_y);
    xq = xe;
    yq = ye;
    zq = in_z;
    case (cordic_mode_e'(in_mode))
      MODE_ROT: begin
        if (in_z > QTR) begin
          xq = -ye;
          yq = xe;
          zq = in_z - QTR;
        end else if (in_z < -QTR) begin
          xq = ye;
          yq = -xe;
          zq = in_z + QTR;
        end
      end
      MODE_VEC: begin
        if (xe[DW-1]) begin
          if (!ye[DW-1]) begin
            xq = ye;
            yq = -xe;
            zq = in_z + QTR;
          end else begin
            xq = -ye;
            yq = xe;
            zq = in_z - QTR;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v0 <= 1'b0;
      m0 <= 1'b0;
      x0 <= '0;
      y0 <= '0;
      z0 <= '0;
    end else if (en) begin
      v0 <= in_valid;
      if (in_valid) begin
        m0 <= in_mode;
        x0 <= xq;
        y0 <= yq;
        z0 <= zq;
      end
    end
  end

  assign vp[0] = v0;
  assign mp[0] = m0;
  assign xp[0] = x0;
  assign yp[0] = y0;
  assign zp[0] = z0;

  for (genvar i = 0; i < STAGES; i++) begin : g_iter
    cordic_iter #(
      .SHIFT(i),
      .DW   (DW),
      .AW   (WIDTH)
    ) u_iter (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .valid_in (vp[i]),
      .mode_in  (mp[i]),
      .x_in     (xp[i]),
      .y_in     (yp[i]),
      .z_in     (zp[i]),
      .atan     (WIDTH'(atan_entry(i, WIDTH))),
      .valid_out(vp[i+1]),
      .mode_out (mp[i+1]),
      .x_out    (xp[i+1]),
      .y_out    (yp[i+1]),
      .z_out    (zp[i+1])
    );
  end

  assign out_valid = vp[STAGES];
  assign out_mode  = mp[STAGES];
  assign out_x     = xp[STAGES];
  assign out_y     = yp[STAGES];
  assign out_z     = zp[STAGES];

endmodule

// File: tb/tb_cordic_pipe.sv
// Randomised bench for cordic_pipe against a floating-point trigonometric model.
// Expected results are queued on accept and compared in order on each output transfer.
module tb_cordic_pipe;
  import cordic_pkg::*;

  localparam int unsigned WIDTH  = 16;
  localparam int unsigned STAGES = 14;
  localparam int unsigned GUARD  = 2;
  localparam int unsigned DW     = WIDTH + GUARD;
  localparam real PI = 3.14159265358979323846;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    in_valid;
  logic                    in_ready;
  logic                    in_mode;
  logic signed [WIDTH-1:0] in_x;
  logic signed [WIDTH-1:0] in_y;
  logic signed [WIDTH-1:0] in_z;
  logic                    out_valid;
  logic                    out_ready;
  logic                    out_mode;
  logic signed [DW-1:0]    out_x;
  logic signed [DW-1:0]    out_y;
  logic signed [WIDTH-1:0] out_z;

  always #5 clk = ~clk;

  cordic_pipe #(
    .WIDTH (WIDTH),
    .STAGES(STAGES),
    .GUARD (GUARD)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_mode  (in_mode),
    .in_x     (in_x),
    .in_y     (in_y),
    .in_z     (in_z),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_mode (out_mode),
    .out_x    (out_x),
    .out_y    (out_y),
    .out_z    (out_z)
  );

  typedef struct {
    logic mode;
    real  ex;
    real  ey;
    real  ez;
    int   tx;
    int   ty;
    int   tz;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   tight = 1'b1;

  task automatic check(input string tag, input longint got, input longint exp, input longint tol);
    n_cmp++;
    if (got - exp > tol || exp - got > tol) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (+/-%0d) at %0t", tag, got, exp, tol, $time);
    end
  endtask

  function automatic longint rnd(input real v);
    if (v >= 0.0) return longint'($floor(v + 0.5));
    return -longint'($floor(-v + 0.5));
  endfunction

  function automatic exp_t model(input logic mode, input int x, input int y, input int z, input bit tgt);
    exp_t e;
    real  k, th, r;
    k  = real'(CORDIC_GAIN_Q15) / 32768.0;
    r  = $sqrt(real'(x) * real'(x) + real'(y) * real'(y));
    e.mode = mode;
    if (mode == 1'b0) begin
      th   = real'(z) * PI / 32768.0;
      e.ex = k * (real'(x) * $cos(th) - real'(y) * $sin(th));
      e.ey = k * (real'(x) * $sin(th) + real'(y) * $cos(th));
      e.ez = 0.0;
      e.tx = tgt ? 4 : 8 + int'(rnd(k * r / 1024.0));
      e.ty = e.tx;
      e.tz = 3;
    end else begin
      e.ex = k * r;
      e.ey = 0.0;
      e.ez = real'(z) + $atan2(real'(y), real'(x)) * 32768.0 / PI;
      e.tx = tgt ? 4 : 8;
      e.ty = tgt ? 4 : 10;
      e.tz = tgt ? 3 : 10;
    end
    return e;
  endfunction

  // Scoreboard: enqueue on accept, compare on each output transfer.
  always @(negedge clk) begin
    if (!rst) begin
      if (in_valid && in_ready)
        sb.push_back(model(in_mode, int'(in_x), int'(in_y), int'(in_z), tight));
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_out", 1, 0, 0);
        end else begin
          exp_t   e;
          longint ez;
          e  = sb.pop_front();
          ez = rnd(e.ez);
          while (ez - longint'(out_z) > 32768) ez -= 65536;
          while (longint'(out_z) - ez > 32768) ez += 65536;
          check("mode", longint'(out_mode), longint'(e.mode), 0);
          check("x", longint'(out_x), rnd(e.ex), e.tx);
          check("y", longint'(out_y), rnd(e.ey), e.ty);
          check("z", longint'(out_z), ez, e.tz);
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the sample is accepted.
  task automatic send(input logic mode, input int x, input int y, input int z);
    in_mode  = mode;
    in_x     = WIDTH'(x);
    in_y     = WIDTH'(y);
    in_z     = WIDTH'(z);
    in_valid = 1'b1;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        return;
      end
    end
    check("send_timeout", 0, 1, 0);
    in_valid = 1'b0;
  endtask

  task automatic send_rand(input logic mode);
    int  r, a;
    real ang;
    r   = int'($urandom_range(30000, 8192));
    a   = int'($urandom_range(65535, 0));
    ang = real'(a) * 2.0 * PI / 65536.0;
    send(mode, int'(rnd(real'(r) * $cos(ang))), int'(rnd(real'(r) * $sin(ang))),
         int'($urandom_range(65535, 0)) - 32768);
  endtask

  task automatic drain();
    for (int t = 0; t < 200; t++) begin
      @(posedge clk);
      #2;
      if (sb.size() == 0) break;
    end
    check("drain", longint'(sb.size()), 0, 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int lat;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_mode   = 1'b0;
    in_x      = '0;
    in_y      = '0;
    in_z      = '0;
    out_ready = 1'b1;
    #12;
    check("rst_valid", longint'(out_valid), 0, 0);
    check("rst_x", longint'(out_x), 0, 0);
    check("rst_y", longint'(out_y), 0, 0);
    check("rst_z", longint'(out_z), 0, 0);
    check("rst_mode", longint'(out_mode), 0, 0);
    check("rst_ready", longint'(in_ready), 1, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Directed corner cases with tight tolerance.
    tight = 1'b1;
    send(1'b0, 9949, 0, 'h2000);
    send(1'b0, 9949, 0, 'h6000);
    send(1'b1, 8192, 8192, 0);
    send(1'b1, -8192, 0, 0);
    send(1'b0, 0, -12000, -'h3000);
    drain();

    // Back-to-back random stream with alternating modes.
    tight = 1'b0;
    for (int i = 0; i < 64; i++) send_rand(logic'(i % 2));
    drain();

    // Hold the output for 5 cycles while the pipe is full.
    fork
      begin
        for (int i = 0; i < 30; i++) send_rand(logic'($urandom_range(1, 0)));
      end
      begin
        repeat (20) @(posedge clk);
        #1;
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          check("stall_ready", longint'(in_ready), 0, 0);
          check("stall_valid", longint'(out_valid), 1, 0);
          if (sb.size() > 0) check("stall_hold_x", longint'(out_x), rnd(sb[0].ex), sb[0].tx);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Asynchronous reset mid-stream, then first-sample latency.
    for (int i = 0; i < 20; i++) send_rand(logic'(i % 2));
    #3;
    rst = 1'b1;
    sb.delete();
    #1;
    check("arst_valid", longint'(out_valid), 0, 0);
    check("arst_x", longint'(out_x), 0, 0);
    check("arst_y", longint'(out_y), 0, 0);
    check("arst_z", longint'(out_z), 0, 0);
    check("arst_mode", longint'(out_mode), 0, 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    tight    = 1'b1;
    in_mode  = 1'b1;
    in_x     = 16'sd12000;
    in_y     = -16'sd5000;
    in_z     = 16'sd1000;
    in_valid = 1'b1;
    lat      = 0;
    for (int t = 0; t < 40; t++) begin
      @(posedge clk);
      #1;
      lat++;
      if (t == 0) in_valid = 1'b0;
      if (out_valid) break;
    end
    check("latency", longint'(lat), longint'(STAGES + 1), 0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected finish before 500000");
    $fatal(1);
  end

endmodule
